// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC framer:
//   - state_e       : framer FSM states
//   - CRC_POLY_DEF  : default generator polynomial (x^8+x^2+x+1, top bit implicit)
//   - CRC_INIT_DEF  : default CRC register value at frame start
// -----------------------------------------------------------------------------
package crc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    WAIT = 3'd2,
    CRC  = 3'd3,
    END  = 3'd4
  } state_e;

  localparam logic [7:0] CRC_POLY_DEF = 8'h07;
  localparam logic [7:0] CRC_INIT_DEF = 8'h00;

endpackage

// File: rtl/crc_serial_lfsr.sv
// -----------------------------------------------------------------------------
// crc_serial_lfsr
// Bit-serial CRC register (Galois form, MSB-first).
// Ports:
//   clk, reset  : clock, synchronous active-low reset (register cleared to 0)
//   init_i      : load CRC_INIT (highest priority)
//   enable_i    : absorb bit_i into the CRC
//   bit_i       : message bit to absorb
//   shift_i     : shift the register left by one (zero fill), used to send
//                 the CRC out MSB-first
//   msb_o       : current register MSB (next CRC bit to transmit)
//   crc_o       : full register value
// -----------------------------------------------------------------------------
module crc_serial_lfsr
  import crc_pkg::*;
#(
  parameter int               CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEF),
  parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(CRC_INIT_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_i,
  input  logic             enable_i,
  input  logic             bit_i,
  input  logic             shift_i,
  output logic             msb_o,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;
  logic             fb_s;

  // Next CRC value: init, absorb one bit, plain shift-out, or hold.
  always_comb begin
    crc_d = crc_q;
    fb_s  = crc_q[CRC_W-1] ^ bit_i;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (enable_i) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb_s ? CRC_POLY : {CRC_W{1'b0}});
    end else if (shift_i) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0};
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_q <= {CRC_W{1'b0}};
    end else begin
      crc_q <= crc_d;
    end
  end

  assign msb_o = crc_q[CRC_W-1];
  assign crc_o = crc_q;

endmodule

// File: rtl/crc_framer.sv
// -----------------------------------------------------------------------------
// crc_framer
// Accepts parallel words on a valid/ready handshake and serialises each frame
// MSB-first, followed by the CRC over the data bits, followed by a one-cycle
// end-of-frame strobe.
// Ports:
//   clk, reset  : clock, synchronous active-low reset
//   in_data     : data word (DATA_W bits)
//   in_valid    : in_data / in_last valid
//   in_last     : current word closes the frame
//   in_ready    : word accepted this cycle when in_valid is also high
//   ser_bit     : serial data or CRC bit
//   ser_valid   : ser_bit carries a frame bit
//   crc_phase   : ser_bit is a CRC bit
//   last        : end-of-frame strobe, one cycle after the final CRC bit
// Build option:
//   CRC_FRAMER_INVERT_EN : transmitted CRC bits are inverted (final XOR with
//                          all-ones); the internal CRC register is unaffected.
// -----------------------------------------------------------------------------
module crc_framer
  import crc_pkg::*;
#(
  parameter int               DATA_W   = 8,
  parameter int               CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEF),
  parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(CRC_INIT_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              crc_phase,
  output logic              last
);

  localparam int CNT_MAX = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

`ifdef CRC_FRAMER_INVERT_EN
  localparam logic CRC_OUT_INV = 1'b1;
`else
  localparam logic CRC_OUT_INV = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              word_last_q, word_last_d;

  logic              ready_s;
  logic              accept_s;
  logic              lfsr_init_s;
  logic              lfsr_en_s;
  logic              lfsr_shift_s;
  logic              crc_msb_s;
  // Full CRC value is available from the LFSR but the framer only needs the MSB.
  logic [CRC_W-1:0]  crc_val_unused_s;

  crc_serial_lfsr #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .init_i   (lfsr_init_s),
    .enable_i (lfsr_en_s),
    .bit_i    (shreg_q[DATA_W-1]),
    .shift_i  (lfsr_shift_s),
    .msb_o    (crc_msb_s),
    .crc_o    (crc_val_unused_s)
  );

  // Output decode from registered state; in_ready is forced low while in reset.
  always_comb begin
    ready_s   = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    crc_phase = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        ready_s = 1'b1;
      end
      DATA: begin
        ser_valid = 1'b1;
        ser_bit   = shreg_q[DATA_W-1];
        // A follow-on word may only be taken on the final bit of a non-last word.
        ready_s   = (cnt_q == DATA_LAST) && !word_last_q;
      end
      WAIT: begin
        ready_s = 1'b1;
      end
      CRC: begin
        ser_valid = 1'b1;
        crc_phase = 1'b1;
        ser_bit   = crc_msb_s ^ CRC_OUT_INV;
      end
      END: begin
        last = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
    in_ready = ready_s & reset;
  end

  // Next-state, shift register, bit counter and LFSR control.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    word_last_d  = word_last_q;
    lfsr_init_s  = 1'b0;
    lfsr_en_s    = 1'b0;
    lfsr_shift_s = 1'b0;
    accept_s     = in_valid & in_ready;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          shreg_d     = in_data;
          word_last_d = in_last;
          cnt_d       = {CNT_W{1'b0}};
          lfsr_init_s = 1'b1;
          state_d     = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        lfsr_en_s = 1'b1;
        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == DATA_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (word_last_q) begin
            state_d = CRC;
          end else if (accept_s) begin
            // Reload on the final bit so the next word follows with no bubble.
            shreg_d     = in_data;
            word_last_d = in_last;
            state_d     = DATA;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = DATA;
        end
      end
      WAIT: begin
        // Frame stays open; the CRC register holds until the next word.
        if (accept_s) begin
          shreg_d     = in_data;
          word_last_d = in_last;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = DATA;
        end else begin
          state_d = WAIT;
        end
      end
      CRC: begin
        lfsr_shift_s = 1'b1;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CRC_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = END;
        end else begin
          state_d = CRC;
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= {DATA_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      word_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      word_last_q <= word_last_d;
    end
  end

endmodule

// File: tb/tb_crc_framer.sv
// -----------------------------------------------------------------------------
// tb_crc_framer
// Self-checking bench for crc_framer (DATA_W = CRC_W = 8, default poly/init).
// Expected CRCs come from polynomial long division over the frame's bit string;
// expected stream timing comes from the frame description (word count, gaps).
// -----------------------------------------------------------------------------
module tb_crc_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       ser_bit;
  logic       ser_valid;
  logic       crc_phase;
  logic       last;

`ifdef CRC_FRAMER_INVERT_EN
  localparam logic [7:0] XOR_OUT = 8'hFF;
`else
  localparam logic [7:0] XOR_OUT = 8'h00;
`endif

  crc_framer dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .crc_phase (crc_phase),
    .last      (last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  bit obs_bit[$];
  bit obs_ph[$];
  int obs_cyc[$];
  int last_q[$];
  int rdy_data, rdy_crc, last_bad, quiet_bad;

  // Frame description
  logic [7:0] fw[16];
  int         fg[16];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (ser_valid) begin
      obs_bit.push_back(ser_bit);
      obs_ph.push_back(crc_phase);
      obs_cyc.push_back(cyc);
      if (in_ready) begin
        if (crc_phase) rdy_crc++;
        else rdy_data++;
      end
    end else if (ser_bit || crc_phase) begin
      quiet_bad++;
    end
    if (last) begin
      last_q.push_back(cyc);
      if (crc_phase || ser_valid) last_bad++;
    end
  end

  task automatic clear_mon();
    obs_bit.delete();
    obs_ph.delete();
    obs_cyc.delete();
    last_q.delete();
    rdy_data = 0; rdy_crc = 0; last_bad = 0; quiet_bad = 0;
  endtask

  // Reference CRC: remainder of (message * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input int nw);
    bit b[$];
    logic [8:0] g;
    logic [7:0] r;
    g = 9'h107;
    for (int w = 0; w < nw; w++)
      for (int k = 7; k >= 0; k--) b.push_back(fw[w][k]);
    for (int k = 0; k < 8; k++) b.push_back(1'b0);
    for (int i = 0; i < b.size() - 8; i++)
      if (b[i]) for (int j = 0; j < 9; j++) b[i+j] = b[i+j] ^ g[8-j];
    r = 8'h00;
    for (int k = 0; k < 8; k++) r[7-k] = b[b.size()-8+k];
    return r ^ XOR_OUT;
  endfunction

  // Present one word; optionally hold in_valid low for 'gap' cycles once the
  // framer is ready for it. Returns the cycle in which the word was accepted.
  task automatic send_word(input logic [7:0] d, input logic lst, input int gap, output int acc);
    bit got;
    acc = -1;
    if (gap > 0) begin
      in_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
        else begin @(posedge clk); #1; end
      end
      if (!got) check("gap_ready_timeout", 32'd0, 32'd1);
      repeat (gap - 1) @(negedge clk);
      @(posedge clk); #1;
    end
    in_data  = d;
    in_last  = lst;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && acc < 0; i++) begin
      @(negedge clk);
      if (in_ready) acc = cyc;
      @(posedge clk); #1;
    end
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_last(input int n, input string name);
    for (int i = 0; i < 200 && last_q.size() < n; i++) @(posedge clk);
    if (last_q.size() < n) check({name, ".last_timeout"}, last_q.size(), n);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input string name, input int nw);
    int acc, acc0, sumg, nb, perr;
    logic [7:0] v;
    clear_mon();
    sumg = 0;
    acc0 = 0;
    for (int w = 0; w < nw; w++) begin
      send_word(fw[w], (w == nw - 1), (w == 0) ? 0 : fg[w], acc);
      if (w == 0) acc0 = acc;
      else sumg += fg[w];
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_last(1, name);
    nb = nw * 8 + 8;
    check({name, ".nbits"}, obs_bit.size(), nb);
    if (obs_bit.size() == nb) begin
      for (int w = 0; w < nw; w++) begin
        v = 8'h00;
        for (int k = 0; k < 8; k++) v = {v[6:0], obs_bit[w*8+k]};
        check({name, ".data"}, v, fw[w]);
      end
      v = 8'h00;
      for (int k = 0; k < 8; k++) v = {v[6:0], obs_bit[nw*8+k]};
      check({name, ".crc"}, v, ref_crc(nw));
      perr = 0;
      for (int i = 0; i < nb; i++) if (obs_ph[i] != (i >= nw * 8)) perr++;
      check({name, ".phase"}, perr, 0);
      check({name, ".first_lat"}, obs_cyc[0] - acc0, 1);
      check({name, ".span"}, obs_cyc[nb-1] - obs_cyc[0] + 1, nb + sumg);
      if (last_q.size() > 0) check({name, ".last_pos"}, last_q[0] - obs_cyc[nb-1], 1);
    end
    check({name, ".nlast"}, last_q.size(), 1);
    check({name, ".rdy_data"}, rdy_data, nw - 1);
    check({name, ".rdy_crc"}, rdy_crc, 0);
    check({name, ".last_clean"}, last_bad, 0);
    check({name, ".quiet"}, quiet_bad, 0);
  endtask

  initial begin : main
    int acc, acc_a, acc_b, nw, nph;
    logic [7:0] v;

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset.outs", {in_ready, ser_valid, ser_bit, crc_phase, last}, 5'b00000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle.ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed single-word frames
    fw[0] = 8'h01; fg[0] = 0;
    run_frame("single01", 1);
    fw[0] = 8'hFF;
    run_frame("singleFF", 1);

    // "123456789" back to back
    for (int i = 0; i < 9; i++) begin
      fw[i] = 8'(8'h31 + i);
      fg[i] = 0;
    end
    run_frame("ascii", 9);

    // Two words with a 3-cycle gap
    fw[0] = 8'h00; fg[0] = 0;
    fw[1] = 8'h01; fg[1] = 3;
    run_frame("gap", 2);

    // Reset during the third CRC bit
    clear_mon();
    send_word(8'h01, 1'b1, 0, acc);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.outs", {in_ready, ser_valid, ser_bit, crc_phase, last}, 5'b00000);
    nph = 0;
    foreach (obs_ph[i]) if (obs_ph[i]) nph++;
    check("rst.crc_bits_before", nph, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("rst.no_last", last_q.size(), 0);
    @(negedge clk);
    check("rst.idle_ready", in_ready, 1);
    @(posedge clk); #1;
    fw[0] = 8'h01;
    run_frame("after_rst", 1);

    // in_valid held high through CRC and END of the previous frame
    clear_mon();
    send_word(8'h01, 1'b1, 0, acc_a);
    send_word(8'hFF, 1'b1, 0, acc_b);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_last(2, "held");
    check("held.nlast", last_q.size(), 2);
    check("held.nbits", obs_bit.size(), 32);
    if (last_q.size() == 2 && obs_bit.size() == 32) begin
      check("held.last_a", last_q[0] - acc_a, 17);
      check("held.accept_b", acc_b - last_q[0], 1);
      check("held.first_b", obs_cyc[16] - acc_b, 1);
      v = 8'h00;
      for (int k = 0; k < 8; k++) v = {v[6:0], obs_bit[24+k]};
      fw[0] = 8'hFF;
      check("held.crc_b", v, ref_crc(1));
    end

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        fw[w] = 8'($urandom);
        fg[w] = (w == 0) ? 0 : $urandom_range(0, 3);
      end
      run_frame("rand", nw);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
